// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared types and constants for the Maxnet front end
package maxnet_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    LOAD    = 3'd1,
    INIT    = 3'd2,
    RUN     = 3'd3,
    RESULT  = 3'd4
  } state_t;

  localparam int FRAME_LEN = 6;

  localparam logic [31:0] ONE         = 32'h3F800000;
  localparam logic [31:0] EPS_DEFAULT = 32'hBDCCCCCD;

endpackage

// File: rtl/maxnet_frame_buffer.sv
// rtl/maxnet_frame_buffer.sv - six-word problem frame store with slot counter
module maxnet_frame_buffer
  import maxnet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        frame_last,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic [31:0] w1,
  output logic [31:0] w2
);

  logic [31:0] slot [FRAME_LEN];
  logic [2:0]  word_cnt;

  // the write that fills the final slot closes the frame
  assign frame_last = wr_en && (word_cnt == 3'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      for (int i = 0; i < FRAME_LEN; i++) slot[i] <= '0;
    end else if (wr_en) begin
      slot[word_cnt] <= wr_data;
      word_cnt       <= frame_last ? 3'd0 : word_cnt + 3'd1;
    end
  end

  assign x1 = slot[0];
  assign x2 = slot[1];
  assign x3 = slot[2];
  assign x4 = slot[3];
  assign w1 = slot[4];
  assign w2 = slot[5];

endmodule

// File: rtl/maxnet_sequencer.sv
// rtl/maxnet_sequencer.sv - frame loader, iteration controller and result port
module maxnet_sequencer
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic [31:0] w1,
  output logic [31:0] w2,
  output logic        ld,
  output logic        sel,
  input  logic        done,
  input  logic [31:0] max,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_timeout,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  state_t            state, state_nx;
  logic [ITER_W-1:0] iter_cnt;
  logic              accept;
  logic              frame_last;

  assign accept = in_valid && in_ready;

  maxnet_frame_buffer u_frame (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept),
    .wr_data    (in_data),
    .frame_last (frame_last),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4),
    .w1         (w1),
    .w2         (w2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (frame_last) state_nx = LOAD;
      LOAD:    state_nx = INIT;
      INIT:    state_nx = RUN;
      RUN:     if (done || iter_cnt == ITER_LAST) state_nx = RESULT;
      RESULT:  if (out_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    busy      = (state != COLLECT);
    ld        = (state == LOAD);
    sel       = (state == RUN);
    out_valid = (state == RESULT);
  end

  // done takes priority over the iteration limit when both land together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt    <= '0;
      out_data    <= '0;
      out_timeout <= 1'b0;
    end else if (state == INIT) begin
      iter_cnt <= '0;
    end else if (state == RUN) begin
      if (done) begin
        out_data    <= max;
        out_timeout <= 1'b0;
      end else if (iter_cnt == ITER_LAST) begin
        out_data    <= max;
        out_timeout <= 1'b1;
      end else begin
        iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// tb/tb_maxnet_sequencer.sv - self-checking bench for maxnet_sequencer
module tb_maxnet_sequencer;
  import maxnet_pkg::*;

  localparam int MAX_ITER = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, ld, sel, done, out_valid, out_timeout, busy;
  logic [31:0] x1, x2, x3, x4, w1, w2, max, out_data;

  always #5 clk = ~clk;

  maxnet_sequencer #(.MAX_ITER(MAX_ITER), .ITER_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2), .ld(ld), .sel(sel),
    .done(done), .max(max), .out_valid(out_valid), .out_data(out_data),
    .out_timeout(out_timeout), .out_ready(out_ready), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] win4(input logic [31:0] a, b, c, d);
    logic [31:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // datapath stand-in: reports done on RUN cycle dp_k (0 = never)
  int          dp_k = 0;
  bit          const_mode = 0;
  logic [31:0] const_max = '0;
  int          run_seen = 0;
  always @(posedge clk) run_seen <= sel ? run_seen + 1 : 0;
  assign done = sel && (dp_k != 0) && (run_seen == dp_k - 1);
  assign max  = const_mode ? const_max : win4(x1, x2, x3, x4);

  // timeline model: phase 0 collecting, 1 load, 2 init, >=3 run cycle (phase-2)
  logic [31:0] m_frame [6];
  int          m_cnt, m_phase, m_r;
  bit          m_res, m_to, m_hit;
  logic [31:0] m_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) m_frame[i] = '0;
      m_cnt = 0; m_phase = 0; m_res = 0; m_to = 0; m_out = '0;
    end else if (m_res) begin
      if (out_ready) begin m_res = 0; m_phase = 0; end
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_frame[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == 6) begin m_cnt = 0; m_phase = 1; end
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else begin
      m_r   = m_phase - 2;
      m_hit = (dp_k == m_r);
      if (m_hit || m_r == MAX_ITER) begin
        m_out = const_mode ? const_max : win4(m_frame[0], m_frame[1], m_frame[2], m_frame[3]);
        m_to  = !m_hit;
        m_res = 1;
      end else begin
        m_phase++;
      end
    end
  end

  bit chk_on = 0;
  bit e_coll;
  always @(negedge clk) begin
    if (chk_on) begin
      e_coll = !m_res && (m_phase == 0);
      chk("in_ready", 32'(in_ready), 32'(e_coll));
      chk("busy", 32'(busy), 32'(!e_coll));
      chk("ld", 32'(ld), 32'(!m_res && m_phase == 1));
      chk("sel", 32'(sel), 32'(!m_res && m_phase >= 3));
      chk("out_valid", 32'(out_valid), 32'(m_res));
      chk("out_data", out_data, m_out);
      chk("out_timeout", 32'(out_timeout), 32'(m_to));
      chk("x1", x1, m_frame[0]);
      chk("x2", x2, m_frame[1]);
      chk("x3", x3, m_frame[2]);
      chk("x4", x4, m_frame[3]);
      chk("w1", w1, m_frame[4]);
      chk("w2", w2, m_frame[5]);
    end
  end

  int cyc = 0;
  int sel_cnt = 0;
  int ld_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sel) sel_cnt <= sel_cnt + 1;
    if (ld)  ld_cnt  <= ld_cnt + 1;
  end

  logic [31:0] fr [6];
  int          acc_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < 6 && guard < 300) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = fr[i];
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
        if (i == 6) acc_cyc = cyc;
      end
      guard++;
      tick();
    end
    in_valid = 1'b0;
    chk("frame_words_accepted", i, 6);
  endtask

  task automatic wait_result(output int lat);
    int g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("result_within_bound", 32'(out_valid), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  int lat, s0, l0;

  initial begin
    for (int i = 0; i < 6; i++) m_frame[i] = '0;
    m_cnt = 0; m_phase = 0; m_res = 0; m_to = 0; m_out = '0;
    chk_on = 1;
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", out_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // three stray words then reset: they must not survive
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hAAAA0001 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_x1", x1, 32'h0);
    chk("midreset_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // nominal frame, back to back
    fr = '{32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, EPS_DEFAULT, ONE};
    dp_k = 2; const_mode = 0; out_ready = 1'b1;
    l0 = ld_cnt; s0 = sel_cnt;
    send_frame(1'b0);
    wait_result(lat);
    chk("nominal_latency", lat, 3 + 2);
    chk("nominal_out_data", out_data, 32'h3F4CCCCD);
    chk("nominal_timeout", 32'(out_timeout), 32'd0);
    chk("nominal_x1", x1, 32'h3E4CCCCD);
    chk("nominal_ld_pulses", ld_cnt - l0, 1);
    chk("nominal_sel_cycles", sel_cnt - s0, 2);
    tick();

    // timeout: done never rises
    fr = '{32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3E400000, EPS_DEFAULT, ONE};
    dp_k = 0; const_mode = 1; const_max = 32'h3F000000;
    s0 = sel_cnt;
    send_frame(1'b0);
    wait_result(lat);
    chk("timeout_sel_cycles", sel_cnt - s0, 4);
    chk("timeout_latency", lat, 3 + MAX_ITER);
    chk("timeout_out_data", out_data, 32'h3F000000);
    chk("timeout_flag", 32'(out_timeout), 32'd1);
    tick();

    // done coincides with the limit: done wins
    fr = '{32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F59999A, 32'h3F0CCCCD, EPS_DEFAULT, ONE};
    dp_k = 4; const_mode = 0;
    send_frame(1'b0);
    wait_result(lat);
    chk("coincide_latency", lat, 3 + 4);
    chk("coincide_out_data", out_data, 32'h3F59999A);
    chk("coincide_timeout", 32'(out_timeout), 32'd0);
    tick();

    // output backpressure
    fr = '{32'h3F700000, 32'h3E000000, 32'h3E100000, 32'h3E200000, EPS_DEFAULT, ONE};
    dp_k = 1; out_ready = 1'b0;
    send_frame(1'b0);
    wait_result(lat);
    chk("bp_latency", lat, 3 + 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", out_data, 32'h3F700000);
    end
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();

    // random input gaps, then stray valid held through the busy phase
    fr = '{32'h3D000000, 32'h3E300000, 32'h3E600000, 32'h3F100000, EPS_DEFAULT, ONE};
    dp_k = 3;
    send_frame(1'b1);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    wait_result(lat);
    chk("gaps_latency", lat, 3 + 3);
    chk("gaps_out_data", out_data, 32'h3F100000);
    chk("gaps_x1", x1, 32'h3D000000);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("gaps_x1_after", x1, 32'h3D000000);

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/maxnet_sequencer.md
# maxnet_sequencer

Front-end loader and run controller for the Maxnet datapath. It collects one problem frame of six IEEE-754 single-precision words over a valid/ready stream: x1, x2, x3, x4, the inhibition weight, and the self weight. It holds the words stable on the datapath inputs, pulses the load, and drives the mux select through the first iteration and then the recurrent iterations. It watches the datapath's done flag, then returns the winning value downstream over a second valid/ready handshake, with a timeout guard.

## Interface
Parameters:
- MAX_ITER, 64: maximum recurrent (sel=1) cycles before forced completion; legal range 1..2^ITER_W-1.
- ITER_W, 7: iteration counter width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  32  upstream word; order x1, x2, x3, x4, w1 (inhibition), w2 (self).
- in_ready  output  1  high only in COLLECT.
- x1, x2, x3, x4  output  32 each  held frame values to datapath.
- w1, w2  output  32 each  held weights to datapath.
- ld  output  1  one-cycle datapath memory load strobe.
- sel  output  1  0 = datapath consumes memory values; 1 = datapath consumes PU feedback.
- done  input  1  datapath single-survivor flag (combinational from PU outputs).
- max  input  32  datapath winner value.
- out_valid  output  1  result valid.
- out_data  output  32  captured winner.
- out_timeout  output  1  qualifies out_data; 1 = MAX_ITER exhausted without done.
- out_ready  input  1  downstream accept.
- busy  output  1  high in every state except COLLECT.

## Operation
- States are COLLECT, LOAD, INIT, RUN, and RESULT.
- COLLECT:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_data into slot word_cnt (0..5) and increments word_cnt.
  - On the accept of slot 5, go to LOAD and clear word_cnt.
  - Frame registers change only on these accepts.
- LOAD: ld=1, sel=0 for exactly one cycle; next state INIT.
- INIT: ld=0, sel=0 for one cycle. The PUs register their first iteration from the memory values. Clear iter_cnt; next state RUN.
- RUN:
  - sel=1; done is sampled every cycle.
  - If done=1: capture max into out_data, out_timeout=0, go to RESULT.
  - Otherwise iter_cnt increments. When iter_cnt==MAX_ITER-1 and done=0: capture max, out_timeout=1, go to RESULT.
  - If done=1 and the limit coincide in the same cycle, done wins (out_timeout=0).
- RESULT:
  - out_valid=1; out_data and out_timeout are held stable until out_valid&&out_ready.
  - Then go to COLLECT.
  - Frame registers keep their values until they are overwritten.
- Outside RUN, sel=0. ld is high only in LOAD.
- In COLLECT, LOAD and INIT, done and max are ignored.
- in_valid outside COLLECT is ignored; no word is consumed.
- Reset mid-operation returns to COLLECT. word_cnt, iter_cnt and out_valid are cleared, and any partial frame is discarded.

## Timing
- Reset values: state=COLLECT, in_ready=1, busy=0, ld=0, sel=0, out_valid=0, out_timeout=0, out_data=0, x1..x4=0, w1=w2=0, word_cnt=0, iter_cnt=0.
- With in_valid held high, six consecutive cycles are accepted with no bubbles.
- LOAD is the cycle after the 6th accept, then INIT follows, then the first RUN cycle.
- Latency from the 6th accept to out_valid: 3 + k cycles, where k = RUN cycles until done (k≥1). The bound is 3 + MAX_ITER.
- out_valid rises on the cycle after capture.
- With out_ready held high, RESULT lasts exactly one cycle. in_ready is 1 on the following cycle.
- All outputs are registered or decoded from state only. No combinational path runs from in_valid/out_ready to in_ready/out_valid.

## Structure
- Shared package maxnet_pkg holds:
  - the state enum {COLLECT, LOAD, INIT, RUN, RESULT};
  - FRAME_LEN=6;
  - float constants ONE=32'h3F800000 and EPS_DEFAULT=32'hBDCCCCCD (-0.1).
- One sub-module, maxnet_frame_buffer: six 32-bit registers with write enable and 3-bit slot index, plus word counter.
- FSM, iteration counter and result register live in maxnet_sequencer.

## Test plan
- Reset mid-frame: assert rst after 3 accepts, then send a full frame → the first three old words are not used; all outputs are at reset values during reset.
- Nominal frame: x=0.2, 0.4, 0.6, 0.8 (3E4CCCCD, 3ECCCCCD, 3F19999A, 3F4CCCCD), w1=BDCCCCCD, w2=3F800000, back-to-back, with a datapath model → ld pulse one cycle after the 6th accept, sel=0 for 2 cycles, then sel=1. Result is out_data=3F4CCCCD, out_timeout=0.
- Timeout: MAX_ITER=4, done tied to 0, max=3F000000 → exactly 4 sel=1 cycles, out_data=3F000000, out_timeout=1.
- Done in the same cycle as the limit: MAX_ITER=4, done asserted on the 4th RUN cycle → out_timeout=0.
- Output backpressure: out_ready low for 10 cycles → out_valid and out_data stable, in_ready=0. After the accept, in_ready=1 on the next cycle.
- Input gaps and stray valid: in_valid toggled randomly during COLLECT; in_valid held high during RUN → frame assembled in order, no word consumed while busy=1.
